// File: rtl/mdu_pkg.sv
// Shared encodings, constants and op-decode helpers for the RV32M multiply/divide unit.
package mdu_pkg;

  localparam int XLEN_DEF = 32;
  localparam logic [XLEN_DEF-1:0] DIV0_QUOT = '1;

  typedef enum logic [2:0] {
    MDU_MUL    = 3'd0,
    MDU_MULH   = 3'd1,
    MDU_MULHSU = 3'd2,
    MDU_MULHU  = 3'd3,
    MDU_DIV    = 3'd4,
    MDU_DIVU   = 3'd5,
    MDU_REM    = 3'd6,
    MDU_REMU   = 3'd7
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } mdu_state_e;

  function automatic logic op_is_div(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic op_rs1_signed(input logic [2:0] op);
    return (op == MDU_MULH) || (op == MDU_MULHSU) || (op == MDU_DIV) || (op == MDU_REM);
  endfunction

  function automatic logic op_rs2_signed(input logic [2:0] op);
    return (op == MDU_MULH) || (op == MDU_DIV) || (op == MDU_REM);
  endfunction

  function automatic logic op_wants_rem(input logic [2:0] op);
    return (op == MDU_REM) || (op == MDU_REMU);
  endfunction

  // MULH, MULHSU and MULHU return the upper half of the product.
  function automatic logic op_wants_high(input logic [2:0] op);
    return !op[2] && (op != MDU_MUL);
  endfunction

endpackage

// File: rtl/mdu_div_core.sv
// Restoring-division datapath: one quotient bit per step over unsigned magnitudes.
module mdu_div_core #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            step,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] dsr_q;
  logic [XLEN:0]   rem_shift;
  logic [XLEN:0]   diff;

  // The top bit of diff is the borrow: set means the trial subtraction failed.
  always_comb begin
    rem_shift = {rem_q, quo_q[XLEN-1]};
    diff      = rem_shift - {1'b0, dsr_q};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      quo_q <= '0;
      rem_q <= '0;
      dsr_q <= '0;
    end else if (load) begin
      quo_q <= dividend;
      rem_q <= '0;
      dsr_q <= divisor;
    end else if (step) begin
      if (!diff[XLEN]) begin
        rem_q <= diff[XLEN-1:0];
        quo_q <= {quo_q[XLEN-2:0], 1'b1};
      end else begin
        rem_q <= rem_shift[XLEN-1:0];
        quo_q <= {quo_q[XLEN-2:0], 1'b0};
      end
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/exe_muldiv.sv
// Iterative RV32M multiply/divide unit for the EXE stage.
// Define MULDIV_FAST_MUL_EN to replace the shift-add multiplier with a single-cycle one.
module exe_muldiv
  import mdu_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            exe_start,
  input  logic [2:0]      exe_op,
  input  logic [XLEN-1:0] exe_rs1_data,
  input  logic [XLEN-1:0] exe_rs2_data,
  input  logic [4:0]      exe_rd,
  input  logic            exe_kill,
  output logic            mdu_busy,
  output logic            mdu_done,
  output logic [XLEN-1:0] mdu_result,
  output logic [4:0]      mdu_rd
);

  mdu_state_e        state;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        op_q;
  logic [4:0]        rd_q;
  logic              neg_q;
  logic              done_q;
  logic [XLEN-1:0]   mcand;
  logic [XLEN-1:0]   acc;
  logic [XLEN-1:0]   mplier;

  logic              accept;
  logic              a_neg;
  logic              b_neg;
  logic [XLEN-1:0]   a_mag;
  logic [XLEN-1:0]   b_mag;
  logic              div_zero;
  logic              div_ovf;
  logic              start_neg;
  logic              imm_valid;
  logic [XLEN-1:0]   imm_result;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] prod_raw;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   div_val;
  logic [XLEN-1:0]   fix_result;
  logic [XLEN-1:0]   div_quo;
  logic [XLEN-1:0]   div_rem;
  logic              div_step;

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_a;
  logic [2*XLEN-1:0] fast_b;
  logic [2*XLEN-1:0] fast_prod;

  // Sign-extending to 2*XLEN lets one unsigned multiply cover all signedness mixes.
  always_comb begin
    fast_a    = {{XLEN{op_rs1_signed(exe_op) & exe_rs1_data[XLEN-1]}}, exe_rs1_data};
    fast_b    = {{XLEN{op_rs2_signed(exe_op) & exe_rs2_data[XLEN-1]}}, exe_rs2_data};
    fast_prod = fast_a * fast_b;
  end
`endif

  always_comb begin
    accept    = (state == ST_IDLE) && exe_start && !exe_kill;
    a_neg     = op_rs1_signed(exe_op) && exe_rs1_data[XLEN-1];
    b_neg     = op_rs2_signed(exe_op) && exe_rs2_data[XLEN-1];
    a_mag     = a_neg ? -exe_rs1_data : exe_rs1_data;
    b_mag     = b_neg ? -exe_rs2_data : exe_rs2_data;
    start_neg = (op_is_div(exe_op) && op_wants_rem(exe_op)) ? a_neg : (a_neg ^ b_neg);

    div_zero  = op_is_div(exe_op) && (exe_rs2_data == '0);
    div_ovf   = op_is_div(exe_op) && op_rs1_signed(exe_op) &&
                (exe_rs1_data == {1'b1, {(XLEN-1){1'b0}}}) && (exe_rs2_data == '1);

    imm_valid  = div_zero || div_ovf;
    imm_result = '0;
    if (div_zero) begin
      imm_result = op_wants_rem(exe_op) ? exe_rs1_data : XLEN'(DIV0_QUOT);
    end else if (div_ovf) begin
      imm_result = op_wants_rem(exe_op) ? '0 : exe_rs1_data;
    end
`ifdef MULDIV_FAST_MUL_EN
    if (!op_is_div(exe_op)) begin
      imm_valid  = 1'b1;
      imm_result = op_wants_high(exe_op) ? fast_prod[2*XLEN-1:XLEN] : fast_prod[XLEN-1:0];
    end
`endif
  end

  // One shift-add step: {acc, mplier} shifts right as product bits retire into mplier.
  always_comb begin
    mul_sum  = {1'b0, acc} + {1'b0, (mplier[0] ? mcand : {XLEN{1'b0}})};
    prod_raw = {acc, mplier};
    prod_fix = neg_q ? -prod_raw : prod_raw;
    div_val  = op_wants_rem(op_q) ? div_rem : div_quo;
    if (op_is_div(op_q)) begin
      fix_result = neg_q ? -div_val : div_val;
    end else begin
      fix_result = op_wants_high(op_q) ? prod_fix[2*XLEN-1:XLEN] : prod_fix[XLEN-1:0];
    end
    div_step = (state == ST_ITER) && op_is_div(op_q);
  end

  mdu_div_core #(
    .XLEN (XLEN)
  ) u_div_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (accept),
    .step      (div_step),
    .dividend  (a_mag),
    .divisor   (b_mag),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  // A kill anywhere past IDLE drops back without touching mdu_result or mdu_rd.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      op_q       <= '0;
      rd_q       <= '0;
      neg_q      <= 1'b0;
      mcand      <= '0;
      acc        <= '0;
      mplier     <= '0;
      mdu_busy   <= 1'b0;
      done_q     <= 1'b0;
      mdu_result <= '0;
      mdu_rd     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (accept) begin
            op_q     <= exe_op;
            rd_q     <= exe_rd;
            neg_q    <= start_neg;
            cnt      <= '0;
            mcand    <= a_mag;
            mplier   <= b_mag;
            acc      <= '0;
            mdu_busy <= 1'b1;
            if (imm_valid) begin
              state      <= ST_DONE;
              mdu_result <= imm_result;
              mdu_rd     <= exe_rd;
              done_q     <= 1'b1;
            end else begin
              state <= ST_ITER;
            end
          end
        end
        ST_ITER: begin
          if (exe_kill) begin
            state    <= ST_IDLE;
            mdu_busy <= 1'b0;
          end else begin
            if (!op_is_div(op_q)) begin
              acc    <= mul_sum[XLEN:1];
              mplier <= {mul_sum[0], mplier[XLEN-1:1]};
            end
            if (cnt == CNT_W'(XLEN-1)) begin
              state <= ST_FIX;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        ST_FIX: begin
          if (exe_kill) begin
            state    <= ST_IDLE;
            mdu_busy <= 1'b0;
          end else begin
            state      <= ST_DONE;
            mdu_result <= fix_result;
            mdu_rd     <= rd_q;
            done_q     <= 1'b1;
          end
        end
        ST_DONE: begin
          state    <= ST_IDLE;
          mdu_busy <= 1'b0;
          done_q   <= 1'b0;
        end
        default: begin
          state    <= ST_IDLE;
          mdu_busy <= 1'b0;
          done_q   <= 1'b0;
        end
      endcase
    end
  end

  // A flush landing in the completion cycle must still squash the writeback.
  assign mdu_done = done_q && !exe_kill;

endmodule
